// File: rtl/pc_pkg.sv
// Shared constants and helpers for the parity checker (pc) and its error counter.
package pc_pkg;

    localparam bit PARITY_EVEN   = 1'b0;
    localparam bit PARITY_ODD    = 1'b1;
    localparam int DEFAULT_CNT_W = 8;

    // An error is flagged when the XOR of data and parity disagrees with the mode.
    function automatic logic parity_error(input logic [3:0] data, input logic par,
                                          input bit odd_mode);
        return (^data) ^ par ^ odd_mode;
    endfunction

endpackage

// File: rtl/pc_err_cnt.sv
// Saturating error counter with synchronous clear and a sticky error flag.
module pc_err_cnt
    import pc_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sticky_reg, sticky_next;

    // Clear wins over a coincident increment.
    always_comb begin
        cnt_next    = cnt_reg;
        sticky_next = sticky_reg;
        if (clr) begin
            cnt_next    = '0;
            sticky_next = 1'b0;
        end else if (inc) begin
            sticky_next = 1'b1;
            if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            sticky_reg <= sticky_next;
        end
    end

    assign err_cnt    = cnt_reg;
    assign err_sticky = sticky_reg;

endmodule

// File: rtl/pc.sv
// Registered 4+1 bit parity checker. The error counter/sticky flag exist only
// when PC_ERR_CNT_EN is defined; otherwise those outputs are tied to zero.
module pc
    import pc_pkg::*;
#(
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             clr_cnt,
    output logic             f,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic             f_valid
);

    localparam bit ODD_MODE = (PARITY_ODD != int'(PARITY_EVEN));

    logic f_reg, f_next;
    logic f_valid_reg, f_valid_next;
    logic word_err;

    assign word_err = parity_error({d, c, b, a}, e, ODD_MODE);

    // f only moves on an accepted word; f_valid tracks acceptance one cycle later.
    always_comb begin
        f_next       = f_reg;
        f_valid_next = in_valid;
        if (in_valid) begin
            f_next = word_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_reg       <= 1'b0;
            f_valid_reg <= 1'b0;
        end else begin
            f_reg       <= f_next;
            f_valid_reg <= f_valid_next;
        end
    end

    assign f       = f_reg;
    assign f_valid = f_valid_reg;

`ifdef PC_ERR_CNT_EN
    pc_err_cnt #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (in_valid & word_err),
        .clr        (clr_cnt),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_cnt        = '0;
    assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_pc.sv
// Self-checking bench: an even/CNT_W=8 instance and an odd/CNT_W=4 instance
// share one stimulus stream and are checked against a behavioural model.
module tb_pc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
    logic clr_cnt = 1'b0;

    logic       f0, fv0, st0;
    logic [7:0] cnt0;
    logic       f1, fv1, st1;
    logic [3:0] cnt1;

    int checks = 0;
    int fails  = 0;
    bit started = 1'b0;

    // model state
    bit m_f0, m_f1, m_fv, m_st0, m_st1;
    int m_cnt0, m_cnt1;

    always #5 clk = ~clk;

    pc #(.PARITY_ODD(0), .CNT_W(8)) u_even (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .e(e), .clr_cnt(clr_cnt),
        .f(f0), .err_cnt(cnt0), .err_sticky(st0), .f_valid(fv0)
    );

    pc #(.PARITY_ODD(1), .CNT_W(4)) u_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .e(e), .clr_cnt(clr_cnt),
        .f(f1), .err_cnt(cnt1), .err_sticky(st1), .f_valid(fv1)
    );

    function automatic bit is_err(input bit [4:0] w, input bit odd);
        int ones = 0;
        for (int i = 0; i < 5; i++) ones += w[i];
        return odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    // Reference behaviour, updated once per rising edge.
    always @(posedge clk) begin
        bit err0, err1;
        err0 = is_err({e, d, c, b, a}, 1'b0);
        err1 = is_err({e, d, c, b, a}, 1'b1);
        if (rst) begin
            m_f0 = 0; m_f1 = 0; m_fv = 0;
            m_cnt0 = 0; m_cnt1 = 0; m_st0 = 0; m_st1 = 0;
            started = 1'b1;
        end else begin
            m_fv = in_valid;
            if (in_valid) begin
                m_f0 = err0;
                m_f1 = err1;
            end
`ifdef PC_ERR_CNT_EN
            if (clr_cnt) begin
                m_cnt0 = 0; m_cnt1 = 0; m_st0 = 0; m_st1 = 0;
            end else if (in_valid) begin
                if (err0) begin m_st0 = 1; if (m_cnt0 < 255) m_cnt0++; end
                if (err1) begin m_st1 = 1; if (m_cnt1 < 15)  m_cnt1++; end
            end
`endif
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("even_f", f0, m_f0);
            chk("even_f_valid", fv0, m_fv);
            chk("even_err_cnt", cnt0, m_cnt0);
            chk("even_sticky", st0, m_st0);
            chk("odd_f", f1, m_f1);
            chk("odd_f_valid", fv1, m_fv);
            chk("odd_err_cnt", cnt1, m_cnt1);
            chk("odd_sticky", st1, m_st1);
        end
    end

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input bit v, input bit [4:0] w, input bit clr, input bit r);
        @(negedge clk);
        in_valid = v; {e, d, c, b, a} = w; clr_cnt = clr; rst = r;
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%0b v=%0b w=%05b clr=%0b | f0=%0b fv=%0b cnt0=%0d st0=%0b | f1=%0b cnt1=%0d st1=%0b",
                 $time, r, v, w, clr, f0, fv0, cnt0, st0, f1, cnt1, st1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 5'b00000, 0, 1);
        step(1, 5'b00001, 1, 1);          // word during reset is discarded
        chk("reset_f", f0, 0);
        chk("reset_f_valid", fv0, 0);
        chk("reset_cnt", cnt0, 0);

        step(1, 5'b00000, 0, 0);
        chk("zero_even_f", f0, 0);
        chk("zero_f_valid", fv0, 1);
        chk("zero_even_cnt", cnt0, 0);
        chk("zero_odd_f", f1, 1);
        step(1, 5'b00001, 0, 0);
        chk("a_only_even_f", f0, 1);
        chk("a_only_odd_f", f1, 0);

        step(0, 5'b00000, 0, 1);
        for (int i = 0; i < 32; i++) begin
            bit [4:0] w;
            w = 5'(i);
            step(1, w, 0, 0);
            chk("sweep_f", f0, ^w);
        end
`ifdef PC_ERR_CNT_EN
        chk("sweep_even_cnt", cnt0, 16);
        chk("sweep_even_sticky", st0, 1);
        chk("sweep_odd_cnt_sat", cnt1, 15);
`else
        chk("sweep_even_cnt_off", cnt0, 0);
        chk("sweep_even_sticky_off", st0, 0);
`endif

        step(0, 5'b00000, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 5'b00000, 0, 0);
`ifdef PC_ERR_CNT_EN
        chk("odd_saturate", cnt1, 15);
`else
        chk("odd_cnt_off", cnt1, 0);
`endif

        step(1, 5'b00001, 1, 0);           // clear with an erroneous word
        chk("clr_even_cnt", cnt0, 0);
        chk("clr_even_sticky", st0, 0);
        chk("clr_even_f", f0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 5'($urandom_range(0, 31)), 0, 0);
            chk("idle_hold_f", f0, 1);
            chk("idle_f_valid", fv0, 0);
        end

        for (int i = 0; i < 5; i++) step(1, 5'b10000, 0, 0);
`ifdef PC_ERR_CNT_EN
        chk("pre_rst_cnt", cnt0, 5);
`endif
        step(1, 5'b00001, 0, 1);
        chk("mid_rst_f", f0, 0);
        chk("mid_rst_fv", fv0, 0);
        chk("mid_rst_cnt", cnt0, 0);
        chk("mid_rst_sticky", st0, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 14) == 0, $urandom_range(0, 39) == 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
REQ-001 Parameter: PARITY_ODD, default 0, 0 = even-parity checking, 1 = odd-parity checking.
REQ-002 Parameter: CNT_W, default 8, width of the error counter; legal range 2..16.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  a..e carry a word to check this cycle.
REQ-007 Port: a  input  1  data bit 0.
REQ-008 Port: b  input  1  data bit 1.
REQ-009 Port: c  input  1  data bit 2.
REQ-010 Port: d  input  1  data bit 3.
REQ-011 Port: e  input  1  received parity bit.
REQ-012 Port: clr_cnt  input  1  clears the error counter and sticky flag.
REQ-013 Port: f  output  1  registered parity-error flag (1 = error).
REQ-014 Port: f_valid  output  1  one-cycle pulse: f updated from a new word.
REQ-015 Port: err_cnt  output  CNT_W  saturating count of erroneous words.
REQ-016 Port: err_sticky  output  1  set by any error since last reset/clear.

Function
REQ-017 Parity value p = a XOR b XOR c XOR d XOR e.
REQ-018 Error condition: p=1 when PARITY_ODD=0; p=0 when PARITY_ODD=1.
REQ-019 On a rising edge with in_valid=1, f SHALL load the error condition; latency exactly 1 cycle.
REQ-020 With in_valid=0, f SHALL hold its previous value and f_valid SHALL be 0 the following cycle.
REQ-021 f_valid SHALL be 1 for exactly the cycle after each accepted word; back-to-back words give continuous f_valid=1.
REQ-022 err_cnt SHALL increment by 1 per accepted erroneous word and saturate at 2^CNT_W-1 (no wrap).
REQ-023 clr_cnt=1 SHALL set err_cnt=0 and err_sticky=0 next cycle, taking priority over a simultaneous increment/set; f and f_valid unaffected.
REQ-024 err_sticky SHALL be set the cycle after any accepted erroneous word and stay set until clr_cnt or rst.
REQ-025 Inputs a..e SHALL be ignored (no state change) when in_valid=0.

Reset
REQ-026 rst=1 at a rising edge SHALL force f=0, f_valid=0, err_cnt=0, err_sticky=0, overriding in_valid and clr_cnt.
REQ-027 A word presented in the same cycle as rst SHALL be discarded; checking resumes the first cycle after rst deasserts.

Configuration
REQ-028 Macro PC_ERR_CNT_EN: when defined, err_cnt and err_sticky behave per REQ-022..024.
REQ-029 When PC_ERR_CNT_EN is undefined, counter/sticky logic SHALL be absent, err_cnt and err_sticky tied to 0, ports retained; f/f_valid behaviour unchanged.

Structure
REQ-030 Shared package pc_pkg SHALL hold the parity-mode constants (PARITY_EVEN=0, PARITY_ODD=1) and default counter width constant.
REQ-031 One sub-module pc_err_cnt (saturating counter with clear and sticky flag) SHALL be instantiated only under PC_ERR_CNT_EN.

Verification
REQ-032 Even mode, rst then a..e=00000 with in_valid=1 -> next cycle f=0, f_valid=1, err_cnt=0.
REQ-033 Even mode, sweep all 32 combos of {e,d,c,b,a} one per cycle -> f equals XOR of word each cycle; final err_cnt=16, err_sticky=1.
REQ-034 Odd mode, a..e=00000 -> f=1; a=1 only -> f=0.
REQ-035 CNT_W=4, 20 consecutive erroneous words -> err_cnt stops at 15.
REQ-036 clr_cnt=1 with erroneous word same cycle -> err_cnt=0, err_sticky=0, f=1; then in_valid=0 for 3 cycles -> f holds 1, f_valid=0.
REQ-037 rst asserted mid-stream with err_cnt=5 -> next cycle all outputs 0; without PC_ERR_CNT_EN err_cnt and err_sticky stay 0 throughout.
